// File: rtl/led_serial_subtractor.sv
// ============================================================================
// led_serial_subtractor
//   Debounced 2-bit switch operands; computes A - B with a bit-serial borrow
//   chain and drives the result onto the four LEDs.
//   Optional macro: SUB_MAGNITUDE_EN (show |A - B| when a borrow occurs).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module led_serial_subtractor #(
    parameter  int DEBOUNCE_CYCLES = 250000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw1,
    input  logic sw2,
    input  logic sw3,
    input  logic sw4,
    output logic LED_1,
    output logic LED_2,
    output logic LED_3,
    output logic LED_4,
    output logic done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [3:0] sw_raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] db;

    state_t     state;
    state_t     state_next;
    logic       busy;
    logic       done_c;

    logic [3:0] snap;
    logic [1:0] a_sr;
    logic [1:0] b_sr;
    logic       brw;
    logic       bit_cnt;
    logic       diff_lo;
    logic       led_brw;
    logic [1:0] led_diff;

    logic       d_bit;
    logic       brw_next;
    logic [1:0] final_diff;
    logic [1:0] shown_diff;

    assign sw_raw = {sw4, sw3, sw2, sw1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                db[i] <= 1'b0;
            end else if (sync2[i] == db[i]) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                db[i] <= sync2[i];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (db != snap) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (bit_cnt) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_c     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign d_bit      = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    assign final_diff = {d_bit, diff_lo};

`ifdef SUB_MAGNITUDE_EN
    assign shown_diff = brw_next ? (~final_diff + 2'd1) : final_diff;
`else
    assign shown_diff = final_diff;
`endif

    // Result LEDs are written on the edge entering DONE so they appear in the
    // same cycle as the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap     <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            brw      <= 1'b0;
            bit_cnt  <= 1'b0;
            diff_lo  <= 1'b0;
            led_brw  <= 1'b0;
            led_diff <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    snap    <= db;
                    a_sr    <= db[1:0];
                    b_sr    <= db[3:2];
                    brw     <= 1'b0;
                    bit_cnt <= 1'b0;
                end
                S_SHIFT: begin
                    brw     <= brw_next;
                    diff_lo <= d_bit;
                    a_sr    <= {1'b0, a_sr[1]};
                    b_sr    <= {1'b0, b_sr[1]};
                    bit_cnt <= 1'b1;
                    if (bit_cnt) begin
                        led_brw  <= brw_next;
                        led_diff <= shown_diff;
                    end
                end
                default: ;
            endcase
        end
    end

    assign LED_1 = busy;
    assign LED_2 = led_brw;
    assign LED_3 = led_diff[1];
    assign LED_4 = led_diff[0];
    assign done  = done_c;

endmodule

`default_nettype wire

// File: doc/led_serial_subtractor.md
Name: led_serial_subtractor

Overview:
- Sequential counterpart to the team's switch-driven combinational LED adder.
- Debounces the four board switches and treats them as two 2-bit operands: A = {sw2, sw1}, B = {sw4, sw3}.
- Computes A − B with a bit-serial borrow-chain FSM and shows the difference, borrow and busy status on the four LEDs.
- Sits directly between the switch pins and the LED pins in a board top level.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clocks needed before a switch's debounced value changes (10 ms at 25 MHz). Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each debounce counter. Derived; do not override.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, active-low, asynchronous assert.
- sw1  input  1  operand A bit 0 (raw, asynchronous, bouncy).
- sw2  input  1  operand A bit 1.
- sw3  input  1  operand B bit 0.
- sw4  input  1  operand B bit 1.
- LED_1  output  1  busy: high while a subtraction is in progress.
- LED_2  output  1  borrow: high when A < B.
- LED_3  output  1  difference bit 1.
- LED_4  output  1  difference bit 0.
- done  output  1  one-cycle pulse when LEDs 2–4 take a new result.

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values:
  - all LEDs 0, done 0;
  - debounced switch vector 0, operand snapshot 0;
  - FSM in IDLE, all counters 0.
- Reset asserted mid-operation aborts immediately to these values. After release, nothing runs until the debounced switches differ from 0.
- Input sync: each sw passes through a 2-flop synchronizer before debounce.
- Debounce, per switch, independent:
  - counter counts while the synced value differs from the debounced value;
  - it clears on any cycle where they match;
  - when the count reaches DEBOUNCE_CYCLES−1 and they still differ, the debounced value takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never propagate.
- FSM states:
  - IDLE: LED_1 = 0. If the debounced vector ≠ snapshot, go to LOAD; otherwise stay.
  - LOAD (1 cycle): snapshot ← debounced vector; a_sr ← A; b_sr ← B; brw ← 0; bit counter ← 0; LED_1 ← 1.
  - SHIFT (exactly 2 cycles, LSB first):
    - d = a0 ^ b0 ^ brw;
    - brw ← (~a0 & b0) | (~(a0 ^ b0) & brw);
    - d shifts into result MSB; a_sr and b_sr shift right.
    - Leave after bit counter = 1.
  - DONE (1 cycle): LED_3/LED_4 ← result[1:0]; LED_2 ← final brw; done = 1; LED_1 ← 0; then go to IDLE.
- Latency: debounced change to new LEDs = 4 clocks (LOAD + 2×SHIFT + DONE); done is high on the 4th clock.
- Switch changes during LOAD/SHIFT/DONE are not sampled: the operands are frozen at LOAD.
  - The debounce logic keeps running during this time.
  - On return to IDLE, a mismatch against the snapshot starts a new run the next cycle, so the final switch state is always displayed.
- Result LEDs hold their last value while busy and while idle; they change only in DONE.
- Arithmetic: the difference is modulo 4 (2-bit two's complement); the borrow is the unsigned A < B flag.
- Simultaneous changes to several switches within one debounce window each resolve independently. The FSM may run once per intermediate debounced vector; the last run reflects the final vector.

Optional Feature:
- Macro SUB_MAGNITUDE_EN.
  - Defined: when the final borrow = 1, DONE loads LED_3/LED_4 with the two's-complement negation of the result (|A − B|, i.e. B − A); LED_2 is still 1.
  - Undefined: LED_3/LED_4 always show the raw modulo-4 difference.
- Latency and all other behaviour are identical in both builds.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
- Reset, then hold all switches 0 for 50 clocks → no done pulse; LEDs = 0000.
- A = 3, B = 1 (sw1 = sw2 = sw3 = 1, sw4 = 0), stable → exactly one done pulse, 4 clocks after debounce; LED_1..4 = 0,0,1,0; LED_1 high for the 3 preceding clocks.
- A = 1, B = 2 → LED_2 = 1 and diff = 11; with SUB_MAGNITUDE_EN, diff = 01.
- sw3 pulsed high for 2 clocks only → no debounced change, no done pulse, LEDs unchanged.
- Start A = 2, B = 0; change to A = 0, B = 3 so that the new value debounces during SHIFT → first done shows 0,0,1,0; a second done follows showing 0,1,0,1 (magnitude build: 0,1,1,1).
- Assert rst_n during SHIFT → all LEDs and done drop to 0 asynchronously; after release with switches still at A = 3, B = 1, a full run completes and shows 0,0,1,0.
